// File: rtl/mem_stage.sv
// Memory-access stage: Wishbone classic data-bus master, load alignment/extension and MEM/WB register.
// Optional bus watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_stage #(
  parameter logic [31:0] RESET_ADDR     = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_mem_i,
  input  logic        flush_i,
  input  logic [31:0] PC_mem_i,
  input  logic [31:0] PC4_mem_i,
  input  logic [4:0]  rd_mem_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] store_data_i,
  input  logic [4:0]  mem_ctrl_i,
  input  logic [31:0] csr_data_mem_i,
  input  logic [11:0] csr_addr_mem_i,
  input  logic [3:0]  trap_code_mem_i,
  input  logic        is_trap_mem_i,
  input  logic        rf_we_mem_i,
  input  logic [1:0]  mux_sel_mem_i,
  input  logic [1:0]  csr_op_mem_i,
  input  logic        is_csr_mem_i,
  input  logic        is_rs1_mem_i,
  input  logic        int_meip_mem_i,
  input  logic        int_mtip_mem_i,
  input  logic        int_msip_mem_i,
  output logic [31:0] PC_wb_o,
  output logic [31:0] PC4_wb_o,
  output logic [4:0]  rd_wb_o,
  output logic [31:0] csr_data_wb_o,
  output logic [11:0] csr_addr_wb_o,
  output logic [3:0]  trap_code_wb_o,
  output logic        is_trap_wb_o,
  output logic        rf_we_wb_o,
  output logic [1:0]  mux_sel_wb_o,
  output logic [1:0]  csr_op_wb_o,
  output logic        is_csr_wb_o,
  output logic        is_rs1_wb_o,
  output logic        int_meip_wb_o,
  output logic        int_mtip_wb_o,
  output logic        int_msip_wb_o,
  output logic [31:0] data_or_alu_o,
  output logic [31:0] dwbm_addr_o,
  output logic [31:0] dwbm_dat_o,
  output logic [3:0]  dwbm_sel_o,
  output logic        dwbm_we_o,
  output logic        dwbm_cyc_o,
  output logic        dwbm_stb_o,
  input  logic [31:0] dwbm_dat_i,
  input  logic        dwbm_ack_i,
  input  logic        dwbm_err_i,
  output logic        stall_o
);

  typedef enum logic {IDLE, BUS} state_t;
  state_t state, state_nx;

  logic       en, we_c, uns_c;
  logic [1:0] size_c, off_c;
  logic       aligned, qual, acc, misal;
  logic [3:0] sel_c;
  logic [31:0] dat_c;

  assign {en, we_c, uns_c, size_c} = mem_ctrl_i;
  assign off_c   = alu_result_i[1:0];
  assign aligned = size_c[1] ? (off_c == 2'b00) : (size_c[0] ? ~off_c[0] : 1'b1);
  assign qual    = valid_mem_i & en & ~is_trap_mem_i & ~flush_i;
  assign acc     = qual & aligned;
  assign misal   = qual & ~aligned;

  always_comb begin
    case (size_c)
      2'b00:   begin sel_c = 4'b0001 << off_c; dat_c = {4{store_data_i[7:0]}};  end
      2'b01:   begin sel_c = 4'b0011 << off_c; dat_c = {2{store_data_i[15:0]}}; end
      default: begin sel_c = 4'b1111;          dat_c = store_data_i;            end
    endcase
  end

  // Transaction context captured at bus start; held until ack/err.
  logic [31:0] addr_q, dat_q;
  logic [3:0]  sel_q;
  logic        we_q, uns_q, flush_q;
  logic [1:0]  size_q;
  logic        in_bus, start, tmo, bus_end, bus_fail, wb_update, bubble;

  assign in_bus   = (state == BUS);
  assign start    = (state == IDLE) & acc;
  assign bus_end  = in_bus & (dwbm_ack_i | dwbm_err_i | tmo);
  assign bus_fail = in_bus & (dwbm_err_i | tmo);
  assign wb_update = ((state == IDLE) & ~acc) | bus_end;
  assign bubble   = in_bus ? (flush_q | flush_i) : (~valid_mem_i | flush_i);

`ifdef MEM_TIMEOUT_EN
  logic [7:0] tmo_cnt;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)       tmo_cnt <= '0;
    else if (start)  tmo_cnt <= '0;
    else if (in_bus) tmo_cnt <= tmo_cnt + 8'd1;
  end
  assign tmo = in_bus & (tmo_cnt == 8'(TIMEOUT_CYCLES));
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (acc) state_nx = BUS;
      BUS:     if (bus_end) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Reset gates the combinational strobes so an abandoned cycle drops at once.
  always_comb begin
    dwbm_cyc_o  = 1'b0;
    dwbm_stb_o  = 1'b0;
    dwbm_addr_o = '0;
    dwbm_sel_o  = '0;
    dwbm_dat_o  = '0;
    dwbm_we_o   = 1'b0;
    stall_o     = 1'b0;
    if (!rst_i) begin
      case (state)
        IDLE: if (acc) begin
          dwbm_cyc_o  = 1'b1;
          dwbm_stb_o  = 1'b1;
          dwbm_addr_o = {alu_result_i[31:2], 2'b00};
          dwbm_sel_o  = sel_c;
          dwbm_dat_o  = dat_c;
          dwbm_we_o   = we_c;
          stall_o     = 1'b1;
        end
        BUS: begin
          dwbm_cyc_o  = 1'b1;
          dwbm_stb_o  = 1'b1;
          dwbm_addr_o = {addr_q[31:2], 2'b00};
          dwbm_sel_o  = sel_q;
          dwbm_dat_o  = dat_q;
          dwbm_we_o   = we_q;
          stall_o     = ~bus_end;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q  <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= '0;
      flush_q <= 1'b0;
    end else if (start) begin
      addr_q  <= alu_result_i;
      dat_q   <= dat_c;
      sel_q   <= sel_c;
      we_q    <= we_c;
      uns_q   <= uns_c;
      size_q  <= size_c;
      flush_q <= 1'b0;
    end else if (in_bus) begin
      flush_q <= flush_q | flush_i;
    end
  end

  logic [31:0] shifted, load_data;
  assign shifted = dwbm_dat_i >> {addr_q[1:0], 3'b000};

  always_comb begin
    case (size_q)
      2'b00:   load_data = {{24{shifted[7] & ~uns_q}}, shifted[7:0]};
      2'b01:   load_data = {{16{shifted[15] & ~uns_q}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      PC_wb_o        <= RESET_ADDR;
      PC4_wb_o       <= RESET_ADDR + 32'd4;
      rd_wb_o        <= '0;
      csr_data_wb_o  <= '0;
      csr_addr_wb_o  <= '0;
      trap_code_wb_o <= '0;
      is_trap_wb_o   <= 1'b0;
      rf_we_wb_o     <= 1'b0;
      mux_sel_wb_o   <= '0;
      csr_op_wb_o    <= '0;
      is_csr_wb_o    <= 1'b0;
      is_rs1_wb_o    <= 1'b0;
      int_meip_wb_o  <= 1'b0;
      int_mtip_wb_o  <= 1'b0;
      int_msip_wb_o  <= 1'b0;
      data_or_alu_o  <= '0;
    end else if (wb_update) begin
      PC_wb_o        <= PC_mem_i;
      PC4_wb_o       <= PC4_mem_i;
      rd_wb_o        <= rd_mem_i;
      csr_data_wb_o  <= csr_data_mem_i;
      csr_addr_wb_o  <= csr_addr_mem_i;
      trap_code_wb_o <= trap_code_mem_i;
      is_trap_wb_o   <= is_trap_mem_i;
      rf_we_wb_o     <= rf_we_mem_i;
      mux_sel_wb_o   <= mux_sel_mem_i;
      csr_op_wb_o    <= csr_op_mem_i;
      is_csr_wb_o    <= is_csr_mem_i;
      is_rs1_wb_o    <= is_rs1_mem_i;
      int_meip_wb_o  <= int_meip_mem_i;
      int_mtip_wb_o  <= int_mtip_mem_i;
      int_msip_wb_o  <= int_msip_mem_i;
      data_or_alu_o  <= alu_result_i;
      if (bubble) begin
        rf_we_wb_o   <= 1'b0;
        is_trap_wb_o <= 1'b0;
        is_csr_wb_o  <= 1'b0;
      end else if (!in_bus && misal) begin
        is_trap_wb_o   <= 1'b1;
        trap_code_wb_o <= we_c ? 4'd6 : 4'd4;
        csr_data_wb_o  <= alu_result_i;
        rf_we_wb_o     <= 1'b0;
      end else if (bus_fail) begin
        is_trap_wb_o   <= 1'b1;
        trap_code_wb_o <= we_q ? 4'd7 : 4'd5;
        csr_data_wb_o  <= addr_q;
        rf_we_wb_o     <= 1'b0;
      end else if (bus_end && !we_q) begin
        data_or_alu_o  <= load_data;
      end
    end
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the XYZ five-stage core, between EX and WB.
- Performs load/store data-bus transactions (Wishbone classic, 32-bit), aligns and extends load data, and detects misaligned or faulting accesses as traps.
- Registers everything into the MEM/WB pipeline register consumed by the writeback stage.
- Stalls the pipeline while a bus cycle is outstanding.

Parameters:
- RESET_ADDR, 32'h0000_0000, reset value of PC_wb_o and PC4_wb_o.
- TIMEOUT_CYCLES, 255, bus watchdog limit. Used only with MEM_TIMEOUT_EN.

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  asynchronous, active-high reset
- valid_mem_i  in  1  EX/MEM holds a valid instruction
- flush_i  in  1  hazard unit: replace current instruction with a bubble
- PC_mem_i, PC4_mem_i  in  32 each  instruction PC and PC+4
- rd_mem_i  in  5  destination register
- alu_result_i  in  32  ALU result / effective address
- store_data_i  in  32  rs2 value for stores
- mem_ctrl_i  in  5  {en, we, unsigned, size[1:0]}; size 00=byte, 01=half, 10=word
- pass-through inputs, each with a *_mem_i suffix:
  - csr_data (32), csr_addr (12), trap_code (4), is_trap (1), rf_we (1), mux_sel (2), csr_op (2), is_csr (1), is_rs1 (1), int_meip/mtip/msip (1 each)
- matching *_wb_o outputs  out  same widths  registered MEM/WB copies
- data_or_alu_o  out  32  load result, or alu_result when not a load
- dwbm_addr_o  out  32  word-aligned bus address
- dwbm_dat_o  out  32  store data
- dwbm_sel_o  out  4  byte lanes
- dwbm_we_o, dwbm_cyc_o, dwbm_stb_o  out  1 each  bus control
- dwbm_dat_i  in  32  read data
- dwbm_ack_i, dwbm_err_i  in  1 each  bus termination
- stall_o  out  1  to hazard unit: freeze IF..EX

Behaviour:
- Reset (asynchronous):
  - state=IDLE; all bus outputs 0.
  - All *_wb_o = 0, except PC_wb_o=RESET_ADDR and PC4_wb_o=RESET_ADDR+4.
  - rf_we_wb_o=0, is_trap_wb_o=0.
- Access qualifier: acc = valid_mem_i & en & ~is_trap_mem_i & ~flush_i & aligned.
- Aligned rule: byte always; half needs addr[0]=0; word needs addr[1:0]=0.
- FSM IDLE:
  - If acc, assert cyc/stb combinationally and load the bus registers from EX/MEM:
    - addr = {alu[31:2], 2'b00}
    - sel: byte = 0001<<addr[1:0], half = 0011<<addr[1:0], word = 1111
    - dat: byte = {4{b}}, half = {2{h}}, word as-is
    - we from mem_ctrl_i
  - stall_o=1; next state BUS.
  - Otherwise the MEM/WB register updates at the clock edge (1-cycle latency).
- FSM BUS:
  - Hold all bus outputs stable.
  - stall_o = ~(ack|err).
  - On ack or err: drop cyc/stb next edge, update MEM/WB, return to IDLE. Minimum memory latency is 2 cycles.
  - If ack and err arrive together, err wins.
- Load data:
  - Shift dwbm_dat_i right by addr[1:0]*8.
  - Sign-extend the byte/half unless the unsigned bit is set; word is unchanged.
  - Store → data_or_alu_o = alu_result.
- Traps (priority order):
  1. Incoming is_trap_mem_i: passed through, no bus cycle.
  2. Misaligned access: is_trap_wb_o=1, trap_code_wb_o=4 (load) / 6 (store), csr_data_wb_o = faulting address, rf_we_wb_o=0, no bus cycle.
  3. dwbm_err_i: trap_code 5 (load) / 7 (store), csr_data_wb_o = address, rf_we_wb_o=0.
- Flush:
  - In IDLE: no bus cycle; the MEM/WB register loads a bubble (rf_we=0, is_trap=0, is_csr=0).
  - In BUS: the cycle runs to ack/err (never aborted), the result is discarded and a bubble is written.
  - flush_i takes no further effect.
- valid_mem_i=0: bubble written, no bus activity.
- Reset mid-cycle: cyc/stb drop immediately; the transaction is abandoned.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - 8-bit counter clears on entering BUS and increments each BUS cycle.
  - At TIMEOUT_CYCLES without ack/err, the cycle is terminated exactly as an err: trap 5/7, stall released, return to IDLE.
- Not defined: no counter; BUS waits indefinitely.

Test Plan:
- Word load, addr 0x100, ack after 3 cycles with 0xDEADBEEF → stall_o high 3 cycles; next edge data_or_alu_o=0xDEADBEEF, rf_we_wb_o=1.
- Signed byte load, addr 0x103, bus data 0x80112233 → sel=1000, data_or_alu_o=0xFFFFFF80. Unsigned variant → 0x00000080.
- Half store 0xABCD to 0x202 → addr=0x200, sel=1100, dat=0xABCDABCD, we=1; rf_we_wb_o=0.
- Word load to 0x101 → no cyc; is_trap_wb_o=1, trap_code_wb_o=4, csr_data_wb_o=0x101. Store variant → code 6.
- dwbm_err_i on store to 0x300 → trap_code_wb_o=7, csr_data_wb_o=0x300. With MEM_TIMEOUT_EN and no response, the same outcome after 255 cycles.
- flush_i during BUS, ack 2 cycles later → cyc drops after ack, MEM/WB holds a bubble (rf_we_wb_o=0). Reset asserted in BUS → cyc_o=0 immediately.
